// File: rtl/ccd_pattern_gen.sv
// ccd_pattern_gen: stands in for the CCD sensor. It emits frame-valid,
// line-valid and 12-bit raw pixels with programmable frame and line timing,
// and fills each frame with a known test pattern.
//
// Ports:
//   iCLK        pixel clock; every output is registered on its rising edge
//   iRST        asynchronous, active-low reset
//   iEN         run enable, looked at only on a frame boundary (IDLE, or the
//               last FGAP cycle)
//   iMODE       pattern select, captured when a frame starts
//   oFVAL       frame valid
//   oLVAL       line valid
//   oDATA       raw pixel for (X,Y) while oLVAL=1, otherwise 0
//   oFrame_Cont number of frames started since reset (wraps at 2^32)
//   oBusy       high whenever the generator is not in IDLE
module ccd_pattern_gen #(
   parameter int unsigned ACTIVE_W = 1280,
   parameter int unsigned ACTIVE_H = 1024,
   parameter int unsigned H_BLANK  = 16,
   parameter int unsigned V_FRONT  = 8,
   parameter int unsigned V_BACK   = 8,
   parameter int unsigned F_GAP    = 32
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iEN,
   input  logic [1:0]  iMODE,
   output logic        oFVAL,
   output logic        oLVAL,
   output logic [11:0] oDATA,
   output logic [31:0] oFrame_Cont,
   output logic        oBusy
);

   localparam int unsigned CW = 16;
   localparam int unsigned DW = 12;

   // Terminal counts: each phase ends on the cycle its counter hits these.
   localparam logic [CW-1:0] X_LAST  = CW'(ACTIVE_W - 1);
   localparam logic [CW-1:0] Y_LAST  = CW'(ACTIVE_H - 1);
   localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);
   localparam logic [CW-1:0] VF_LAST = CW'(V_FRONT - 1);
   localparam logic [CW-1:0] VB_LAST = CW'(V_BACK - 1);
   localparam logic [CW-1:0] FG_LAST = CW'(F_GAP - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_VFRONT,
      S_LINE,
      S_HBLANK,
      S_VBACK,
      S_FGAP
   } state_t;

   state_t        state;
   logic [CW-1:0] x;
   logic [CW-1:0] y;
   logic [CW-1:0] cnt;
   logic [1:0]    mode_q;
   logic          start_c;

   // Pixel value for (px,py). f is the low nibble of the current frame count.
   function automatic logic [DW-1:0] pixel(input logic [1:0]    m,
                                           input logic [DW-1:0] px,
                                           input logic [DW-1:0] py,
                                           input logic [3:0]    f);
      logic [DW-1:0] p;
      case (m)
         2'd0:    p = px;
         2'd1:    p = py;
         2'd2:    p = (px[0] ^ py[0]) ? 12'h000 : 12'hFFF;
         default: p = {f, py[3:0], px[3:0]};
      endcase
      return p;
   endfunction

   // A new frame may start only from IDLE or on the final FGAP cycle.
   assign start_c = iEN && ((state == S_IDLE) ||
                            ((state == S_FGAP) && (cnt == FG_LAST)));

   // Timing FSM. Outputs are assigned together with the state they belong to,
   // so they come straight from flops and line up with the state register.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state       <= S_IDLE;
         x           <= '0;
         y           <= '0;
         cnt         <= '0;
         mode_q      <= 2'd0;
         oFVAL       <= 1'b0;
         oLVAL       <= 1'b0;
         oDATA       <= '0;
         oFrame_Cont <= '0;
         oBusy       <= 1'b0;
      end else if (start_c) begin
         state       <= S_VFRONT;
         x           <= '0;
         y           <= '0;
         cnt         <= '0;
         mode_q      <= iMODE;
         oFVAL       <= 1'b1;
         oLVAL       <= 1'b0;
         oDATA       <= '0;
         oFrame_Cont <= oFrame_Cont + 32'd1;
         oBusy       <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               oBusy <= 1'b0;
            end

            S_VFRONT: begin
               if (cnt == VF_LAST) begin
                  state <= S_LINE;
                  cnt   <= '0;
                  x     <= '0;
                  oLVAL <= 1'b1;
                  oDATA <= pixel(mode_q, 12'd0, y[DW-1:0], oFrame_Cont[3:0]);
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            S_LINE: begin
               if (x == X_LAST) begin
                  oLVAL <= 1'b0;
                  oDATA <= '0;
                  cnt   <= '0;
                  if (y < Y_LAST) begin
                     state <= S_HBLANK;
                     y     <= y + 16'd1;
                  end else begin
                     state <= S_VBACK;
                  end
               end else begin
                  x     <= x + 16'd1;
                  oDATA <= pixel(mode_q, x[DW-1:0] + 12'd1, y[DW-1:0],
                                 oFrame_Cont[3:0]);
               end
            end

            S_HBLANK: begin
               if (cnt == HB_LAST) begin
                  state <= S_LINE;
                  cnt   <= '0;
                  x     <= '0;
                  oLVAL <= 1'b1;
                  oDATA <= pixel(mode_q, 12'd0, y[DW-1:0], oFrame_Cont[3:0]);
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            S_VBACK: begin
               if (cnt == VB_LAST) begin
                  state <= S_FGAP;
                  cnt   <= '0;
                  oFVAL <= 1'b0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            S_FGAP: begin
               // Restart with iEN=1 is handled by start_c above.
               if (cnt == FG_LAST) begin
                  state <= S_IDLE;
                  cnt   <= '0;
                  oBusy <= 1'b0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            default: begin
               state <= S_IDLE;
               oFVAL <= 1'b0;
               oLVAL <= 1'b0;
               oDATA <= '0;
               oBusy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ccd_pattern_gen.sv
// tb_ccd_pattern_gen: randomized bench for ccd_pattern_gen with small frame
// timing. The reference model builds each frame as a list of
// {fval, lval, data} cycles, working from the frame layout, and plays the
// list back one cycle at a time.
module tb_ccd_pattern_gen;

   localparam int unsigned W  = 4;
   localparam int unsigned H  = 3;
   localparam int unsigned HB = 2;
   localparam int unsigned VF = 3;
   localparam int unsigned VB = 2;
   localparam int unsigned FG = 5;
   localparam int unsigned FVAL_LEN = VF + W * H + (H - 1) * HB + VB;
   localparam int unsigned PERIOD   = FVAL_LEN + FG;

   logic        clk;
   logic        rst;
   logic        en;
   logic [1:0]  mode;
   logic        fval;
   logic        lval;
   logic [11:0] data;
   logic [31:0] frame_cnt;
   logic        busy;

   ccd_pattern_gen #(
      .ACTIVE_W (W),
      .ACTIVE_H (H),
      .H_BLANK  (HB),
      .V_FRONT  (VF),
      .V_BACK   (VB),
      .F_GAP    (FG)
   ) dut (
      .iCLK        (clk),
      .iRST        (rst),
      .iEN         (en),
      .iMODE       (mode),
      .oFVAL       (fval),
      .oLVAL       (lval),
      .oDATA       (data),
      .oFrame_Cont (frame_cnt),
      .oBusy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                    tag, got, exp, $time);
   endtask

   // Reference model state
   logic [13:0] q[$];          // {fval, lval, data[11:0]} per cycle
   int unsigned m_frame = 0;
   bit          m_f = 0, m_l = 0, m_busy = 0;
   int unsigned m_d = 0;
   bit          idle_between = 1;

   function automatic int unsigned pix(int unsigned m, int unsigned px,
                                       int unsigned py, int unsigned f);
      case (m)
         0:       return px % 4096;
         1:       return py % 4096;
         2:       return ((px + py) % 2 == 0) ? 4095 : 0;
         default: return (f % 16) * 256 + (py % 16) * 16 + (px % 16);
      endcase
   endfunction

   task automatic build_frame(input int unsigned m);
      for (int i = 0; i < VF; i++) q.push_back({1'b1, 1'b0, 12'd0});
      for (int yy = 0; yy < H; yy++) begin
         for (int xx = 0; xx < W; xx++)
            q.push_back({1'b1, 1'b1, 12'(pix(m, xx, yy, m_frame))});
         if (yy < H - 1)
            for (int i = 0; i < HB; i++) q.push_back({1'b1, 1'b0, 12'd0});
      end
      for (int i = 0; i < VB; i++) q.push_back({1'b1, 1'b0, 12'd0});
      for (int i = 0; i < FG; i++) q.push_back({1'b0, 1'b0, 12'd0});
   endtask

   task automatic model_pop();
      logic [13:0] e;
      e = q.pop_front();
      m_f = e[13];
      m_l = e[12];
      m_d = e[11:0];
      m_busy = 1;
   endtask

   // Advance the model by one clock using the inputs the DUT sees.
   task automatic model_step();
      if (q.size() == 0) begin
         if (en) begin
            m_frame++;
            build_frame(mode);
            model_pop();
         end else begin
            m_f = 0; m_l = 0; m_d = 0; m_busy = 0;
            idle_between = 1;
         end
      end else begin
         model_pop();
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_frame = 0; m_f = 0; m_l = 0; m_d = 0; m_busy = 0;
      idle_between = 1;
   endtask

   // Observed-timing trackers
   int unsigned cyc = 0, last_rise = 0, run = 0;
   bit          have_rise = 0, prev_f = 0;

   task automatic step();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      check("fval",  32'(fval),  32'(m_f));
      check("lval",  32'(lval),  32'(m_l));
      check("data",  32'(data),  m_d);
      check("busy",  32'(busy),  32'(m_busy));
      check("frame", frame_cnt,  m_frame);
      if (fval && !prev_f) begin
         if (have_rise && !idle_between)
            check("period", cyc - last_rise, PERIOD);
         last_rise = cyc;
         have_rise = 1;
         idle_between = 0;
         run = 0;
      end
      if (fval) run++;
      if (!fval && prev_f) check("fval_len", run, FVAL_LEN);
      prev_f = fval;
   endtask

   task automatic wait_lval();
      int k;
      k = 0;
      while (!lval && k < 200) begin
         step();
         k++;
      end
      check("wait_lval", 32'(lval), 32'd1);
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; mode = 2'd0;
      repeat (2) @(negedge clk);
      check("rst_fval",  32'(fval), 0);
      check("rst_lval",  32'(lval), 0);
      check("rst_data",  32'(data), 0);
      check("rst_frame", frame_cnt, 0);
      check("rst_busy",  32'(busy), 0);
      rst = 1'b1;
      repeat (3) step();

      // Single-cycle enable pulse: exactly one frame, then IDLE.
      en = 1'b1; mode = 2'd0;
      step();
      en = 1'b0;
      repeat (35) step();
      check("pulse_frames", frame_cnt, 1);
      check("pulse_idle", 32'(busy), 0);

      // Continuous run, horizontal ramp.
      en = 1'b1;
      repeat (80) step();
      // Bayer checker, then tagged pattern.
      mode = 2'd2;
      repeat (60) step();
      mode = 2'd3;
      repeat (60) step();
      // Mode change mid-frame takes effect only on the next frame.
      mode = 2'd0;
      repeat (30) step();
      wait_lval();
      mode = 2'd1;
      repeat (60) step();

      // Enable dropped mid-line: frame still completes, then IDLE.
      wait_lval();
      en = 1'b0;
      repeat (40) step();
      check("drop_idle", 32'(busy), 0);

      // Randomized enable and mode.
      repeat (1500) begin
         en   = ($urandom % 8) != 0;
         mode = 2'($urandom % 4);
         step();
      end

      // Asynchronous reset mid-line.
      en = 1'b1;
      wait_lval();
      step();
      #2 rst = 1'b0;
      #1;
      check("arst_fval",  32'(fval), 0);
      check("arst_lval",  32'(lval), 0);
      check("arst_data",  32'(data), 0);
      check("arst_frame", frame_cnt, 0);
      check("arst_busy",  32'(busy), 0);
      model_reset();
      have_rise = 0; prev_f = 0; run = 0;
      en = 1'b0;
      @(negedge clk) rst = 1'b1;
      repeat (5) step();
      en = 1'b1; mode = 2'd3;
      repeat (60) step();
      en = 1'b0;
      repeat (30) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
